// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
// Contents: FSM state encoding, frame geometry constants, state-decode helper.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CSUM state).
package imem_loader_pkg;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_W          = LEN_BYTES * 8;
    localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // Fixed encodings so the checksum build does not renumber the other states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM   = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    // True in the states that consume stream bytes and stall the core.
    function automatic logic in_frame(input state_e s);
        logic r;
        r = (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        r = r || (s == ST_CSUM);
`endif
        return r;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles little-endian words from a byte stream.
// Ports:
//   clock, reset        - clock, asynchronous active-high reset
//   clear_i             - restart word assembly (new load)
//   byte_valid_i/byte_i - one data byte accepted this cycle
//   word_complete_c     - combinational: this byte completes a word
//   word_valid_o        - registered one-cycle strobe, word_o holds the word
//   word_o              - assembled word (first byte in bits 7:0)
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic                  word_complete_c,
    output logic                  word_valid_o,
    output logic [DATA_WIDTH-1:0] word_o
);

    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  valid_q;

    // Shift new bytes in from the top so the first byte ends up in bits 7:0.
    always_comb begin
        cnt_d           = cnt_q;
        word_d          = word_q;
        word_complete_c = byte_valid_i && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (byte_valid_i) begin
            cnt_d  = cnt_q + BYTE_CNT_W'(1);
            word_d = {byte_i, word_q[DATA_WIDTH-1:8]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= word_complete_c;
        end
    end

    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory.
// Frame: N (16-bit, little-endian) then 4*N data bytes, optional checksum byte.
// Ports:
//   clock, reset                 - clock, asynchronous active-high reset
//   load_start                   - arms a load from IDLE/DONE/ERR
//   rx_valid/rx_data/rx_ready    - byte stream handshake
//   writeEnable/Address/Data     - one-cycle memory write per word
//   cpu_hold                     - core stall while a load is in progress
//   done/error                   - sticky completion / abort flags
// Macro IMEM_LOADER_CHECKSUM_EN: adds a trailing modulo-256 checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned MAX_WORDS = 32'(1) << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e FRAME_END = ST_CSUM;
`else
    localparam state_e FRAME_END = ST_DONE;
`endif

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rx_ready_q, cpu_hold_q, done_q, error_q;
    logic                  accept_c, clear_c, last_word_c;
    logic [LEN_W-1:0]      len_full_c;
    logic                  pk_complete_c, pk_valid;
    logic [DATA_WIDTH-1:0] pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    assign accept_c    = rx_valid && rx_ready_q;
    assign len_full_c  = {rx_data, len_q[7:0]};
    // addr_q equals the index of the word being assembled or written.
    assign last_word_c = (LEN_W'(addr_q) == (len_q - LEN_W'(1)));

    imem_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clock           (clock),
        .reset           (reset),
        .clear_i         (clear_c),
        .byte_valid_i    (accept_c && (state_q == ST_DATA)),
        .byte_i          (rx_data),
        .word_complete_c (pk_complete_c),
        .word_valid_o    (pk_valid),
        .word_o          (pk_word)
    );

    // Next-state, length capture, address counter and checksum.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        clear_c = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        if (accept_c && (state_q != ST_CSUM)) begin
            sum_d = sum_q + rx_data;
        end
`endif
        // Advance after each write except the last, so the counter never wraps.
        if (pk_valid && !last_word_c) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_start) begin
                    state_d = ST_LEN_LO;
                    len_d   = '0;
                    addr_d  = '0;
                    clear_c = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_LEN_LO: begin
                if (accept_c) begin
                    len_d[7:0] = rx_data;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept_c) begin
                    len_d[LEN_W-1:8] = rx_data;
                    if (len_full_c == '0) begin
                        state_d = FRAME_END;
                    end else if (32'(len_full_c) > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Leave on the final byte; its write lands in the following cycle.
                if (pk_complete_c && last_word_c) begin
                    state_d = FRAME_END;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept_c) begin
                    state_d = (8'(sum_q + rx_data) == 8'h00) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered status outputs, decoded from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            rx_ready_q <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            rx_ready_q <= in_frame(state_d);
            cpu_hold_q <= in_frame(state_d);
            done_q     <= (state_d == ST_DONE);
            error_q    <= (state_d == ST_ERR);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    assign rx_ready     = rx_ready_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign writeEnable  = pk_valid;
    assign writeAddress = addr_q;
    assign writeData    = pk_word;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven frames plus reset and mid-load corner sequences.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, writeEnable, cpu_hold, done, error;
    logic [11:0] writeAddress;
    logic [31:0] writeData;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clock        (clock),
        .reset        (reset),
        .load_start   (load_start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .writeEnable  (writeEnable),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error)
    );

    always #5 clock = ~clock;

    // Record every write strobe seen, one entry per cycle.
    always @(negedge clock) begin
        if (writeEnable === 1'b1) begin
            wr_addr.push_back(32'(writeAddress));
            wr_data.push_back(writeData);
        end
    end

    typedef struct {
        logic [127:0] bytes;   // byte i at bits 8i+7:8i
        int           nb;
        bit           toggle;  // rx_valid low between bytes
        int           nw;
        logic [95:0]  words;   // expected word j at bits 32j+31:32j
        bit           exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            rx_valid = 1'b0;
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_err++;
            $display("FAIL rx_ready_timeout: got rx_ready=%b expected 1", rx_ready);
        end
        tick();
        rx_valid = 1'b0;
    endtask

    // Run vector k; poke_at >= 0 pulses load_start before that byte index.
    task automatic do_vec(input int k, input int poke_at);
        logic [127:0] fb;
        int           nb;
        logic [7:0]   sum;
        fb  = vecs[k].bytes;
        nb  = vecs[k].nb;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!vecs[k].exp_err) begin
            sum = 8'h00;
            for (int i = 0; i < nb; i++) sum = sum + fb[8*i +: 8];
            fb[8*nb +: 8] = 8'h00 - sum;
            nb++;
        end
`else
        sum = 8'h00;
`endif
        wr_addr.delete();
        wr_data.delete();
        pulse_load();
        for (int i = 0; i < nb; i++) begin
            if (i == poke_at) pulse_load();
            send_byte(fb[8*i +: 8], vecs[k].toggle);
        end
        repeat (3) tick();
        check($sformatf("v%0d_nwrites", k), 32'(wr_addr.size()), 32'(vecs[k].nw));
        for (int j = 0; j < vecs[k].nw; j++) begin
            if (j < wr_addr.size()) begin
                check($sformatf("v%0d_addr%0d", k, j), wr_addr[j], 32'(j));
                check($sformatf("v%0d_data%0d", k, j), wr_data[j], vecs[k].words[32*j +: 32]);
            end
        end
        check($sformatf("v%0d_done", k),     32'(done),        32'(!vecs[k].exp_err));
        check($sformatf("v%0d_error", k),    32'(error),       32'(vecs[k].exp_err));
        check($sformatf("v%0d_rx_ready", k), 32'(rx_ready),    32'd0);
        check($sformatf("v%0d_cpu_hold", k), 32'(cpu_hold),    32'd0);
        check($sformatf("v%0d_we_idle", k),  32'(writeEnable), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready),     32'd0);
        check({tag, "_we"},       32'(writeEnable),  32'd0);
        check({tag, "_waddr"},    32'(writeAddress), 32'd0);
        check({tag, "_wdata"},    writeData,         32'd0);
        check({tag, "_hold"},     32'(cpu_hold),     32'd0);
        check({tag, "_done"},     32'(done),         32'd0);
        check({tag, "_error"},    32'(error),        32'd0);
    endtask

    initial begin
        vecs[0] = '{128'hDEADBEEF_0001, 6, 1'b0, 1, 96'hDEADBEEF, 1'b0};
        vecs[1] = '{128'h01234567_CAFEF00D_11223344_0003, 14, 1'b1, 3,
                    {32'h01234567, 32'hCAFEF00D, 32'h11223344}, 1'b0};
        vecs[2] = '{128'h1001, 2, 1'b0, 0, 96'h0, 1'b1};
        vecs[3] = '{128'h0000, 2, 1'b0, 0, 96'h0, 1'b0};
        vecs[4] = '{128'h44332211_AABBCCDD_0002, 10, 1'b0, 2,
                    {32'h0, 32'h44332211, 32'hAABBCCDD}, 1'b0};

        // Reset state.
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) do_vec(k, -1);

        // Reset after 6 of 8 data bytes: immediate zero outputs, only word 0 written.
        wr_addr.delete();
        wr_data.delete();
        pulse_load();
        for (int i = 0; i < 8; i++) send_byte(vecs[4].bytes[8*i +: 8], 1'b0);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        check("midrst_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) begin
            check("midrst_addr0", wr_addr[0], 32'd0);
            check("midrst_data0", wr_data[0], 32'hAABBCCDD);
        end
        tick();
        reset = 1'b0;
        tick();
        do_vec(0, -1);

        // load_start in the middle of DATA is ignored.
        do_vec(4, 5);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Matching and mismatching checksum trailers.
        begin
            logic [55:0] cf;
            for (int t = 0; t < 2; t++) begin
                cf = (t == 0) ? 56'hEC_00000013_0001 : 56'hED_00000013_0001;
                wr_addr.delete();
                wr_data.delete();
                pulse_load();
                for (int i = 0; i < 7; i++) send_byte(cf[8*i +: 8], 1'b0);
                repeat (3) tick();
                check($sformatf("csum%0d_done", t),    32'(done),  32'(t == 0));
                check($sformatf("csum%0d_error", t),   32'(error), 32'(t == 1));
                check($sformatf("csum%0d_nwrites", t), 32'(wr_addr.size()), 32'd1);
                if (wr_addr.size() > 0) begin
                    check($sformatf("csum%0d_addr", t), wr_addr[0], 32'd0);
                    check($sformatf("csum%0d_data", t), wr_data[0], 32'h00000013);
                end
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
